imem_loader: RTL
================

# imem_loader

Boot-time writer for the instruction memory. Accepts a framed little-endian byte stream (from the UART receiver or debug bridge) over a valid/ready handshake, assembles 32-bit instruction words and issues single-cycle writes to the instruction RAM's write port. Holds the core in reset (`cpu_hold`) until a complete frame with a correct checksum has been written.

## Interface
- `DEPTH`, 64: instruction RAM depth in words; maximum accepted word count.
- `ADDR_W`, 6: word-address width; must satisfy 2^ADDR_W >= DEPTH.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE, DONE and ERR; ignored otherwise.
- `rx_data`  in  8  incoming frame byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs when `rx_valid && rx_ready` on a rising edge.
- `wr_en`  out  1  instruction RAM write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  word address of the write.
- `wr_data`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the core in reset while high.
- `done`  out  1  frame loaded and checksum matched.
- `error`  out  1  frame rejected (bad length or checksum).

## Operation
- Frame: LEN_LO, LEN_HI (word count N, 16-bit LE), then 4·N data bytes (each word LE, byte 0 = bits 7:0), then CSUM.
- CSUM must equal the 8-bit sum (mod 256) of every preceding frame byte (length and data bytes).
- States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
- IDLE/DONE/ERR + `start` -> LEN0; clears `done`, `error`, checksum accumulator, word address, byte index; sets `cpu_hold`=1.
- LEN0: accept LEN_LO -> LEN1.
- LEN1: accept LEN_HI; N==0 or N>DEPTH -> ERR, else -> DATA.
- DATA: 2-bit byte index shifts bytes into the word register; on the 4th byte, register the write and increment the word address; after word N-1 -> CSUM.
- CSUM: accept byte; match -> DONE, mismatch -> ERR.
- DONE: `done`=1, `cpu_hold`=0. ERR: `error`=1, `cpu_hold`=1. Both hold until `start` or reset.
- `rx_ready`=1 exactly in LEN0, LEN1, DATA and CSUM; 0 elsewhere. A byte with `rx_valid` low is not consumed; any number of idle cycles between bytes is allowed.
- Word address never wraps: at most DEPTH writes per frame, addresses 0..N-1 in order.
- Words written before a checksum failure stay in RAM; no rollback.
- `start` while a frame is in progress is ignored.
- Reset (any state): all registers return to reset values and the state to IDLE. Partially written RAM is not cleared.

## Timing
- Reset values: `rx_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_hold`=1, `done`=0, `error`=0.
- `start` high at edge k -> `rx_ready`=1 from cycle k+1.
- 4th byte of a word accepted at edge k -> `wr_en`=1 with valid `wr_addr`/`wr_data` during cycle k+1 only. `wr_addr`/`wr_data` hold their values after the strobe.
- Back-to-back bytes sustain one byte per cycle; a write overlapping the next byte acceptance (including CSUM) is legal.
- LEN_HI accepted at edge k with bad N -> `error`=1 and `rx_ready`=0 in cycle k+1.
- CSUM accepted at edge k -> `done` or `error` in cycle k+1; `cpu_hold` falls in cycle k+1 on success.
- No combinational path from `rx_valid` to `rx_ready`; all outputs registered.

## Test plan
- N=1, bytes 01 00 93 00 50 00 E4 back-to-back -> one `wr_en`, `wr_addr`=0, `wr_data`=0x00500093, then `done`=1, `cpu_hold`=0, `error`=0.
- N=0 (00 00) -> `error`=1 next cycle, `rx_ready`=0, no `wr_en`, `cpu_hold` stays 1; `start` then clears `error`.
- N=65 with DEPTH=64 (41 00) -> `error`=1, no writes; N=64 with random data and random `rx_valid` gaps -> 64 writes at addresses 0..63, data matching the stream, `done`=1.
- N=2 with CSUM off by one -> both words written (addresses 0, 1), `error`=1, `done`=0, `cpu_hold`=1.
- `start` pulsed during DATA -> ignored, frame completes normally; `start` in DONE -> `done` drops, `cpu_hold` rises, second frame loads.
- `reset_n` low mid-DATA (after 2 of 4 bytes) -> all outputs at reset values immediately, state IDLE; new `start` and full frame load correctly from address 0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// The master side is the loader itself; the slave side is the surrounding source/RAM.
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length/data/checksum byte frame,
// writes 32-bit LE words to the instruction RAM and releases the core on success.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  imem_loader_if.master  bus,
  output logic           cpu_hold,
  output logic           done,
  output logic           error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [7:0]        csum;
  logic [1:0]        byte_idx;
  logic [23:0]       word_sr;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] n_last;
  logic              rx_ready_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;

  logic              take;
  logic [15:0]       n_full;

  assign take   = bus.rx_valid && rx_ready_q;
  assign n_full = {bus.rx_data, len_lo};

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      len_lo     <= '0;
      csum       <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      widx       <= '0;
      n_last     <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN0;
            rx_ready_q <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_hold   <= 1'b1;
            csum       <= '0;
            widx       <= '0;
            byte_idx   <= '0;
          end
        end
        S_LEN0: begin
          if (take) begin
            len_lo <= bus.rx_data;
            csum   <= csum + bus.rx_data;
            state  <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (take) begin
            csum <= csum + bus.rx_data;
            if (n_full == 16'd0 || n_full > 16'(DEPTH)) begin
              state      <= S_ERR;
              error      <= 1'b1;
              rx_ready_q <= 1'b0;
            end else begin
              // Stored as N-1 so the address counter stops at the last word and never wraps.
              n_last <= ADDR_W'(n_full - 16'd1);
              state  <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            csum     <= csum + bus.rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= widx;
              wr_data_q <= {bus.rx_data, word_sr};
              if (widx == n_last) state <= S_CSUM;
              else                widx  <= widx + 1'b1;
            end else begin
              word_sr <= {bus.rx_data, word_sr[23:8]};
            end
          end
        end
        S_CSUM: begin
          if (take) begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
